// File: rtl/cpu6_arb_muxnds_pkg.sv
// Shared types and helpers for the cpu6 N:1 arbitrated datapath mux.
// The lock FSM state encoding lives here so the top and the bench agree on it.
package cpu6_arb_muxnds_pkg;

  // Lock FSM states: IDLE re-arbitrates every beat, LOCK pins the grant to one channel.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  // Round-robin successor of a granted index, wrapping at num-1 -> 0.
  function automatic int rr_next(input int idx, input int num);
    return (idx == num - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cpu6_arb_muxnds_pick.sv
// cpu6_rr_pick: combinational round-robin picker.
// Finds the first request at index >= ptr, searching upward and wrapping modulo NUM.
// Produces a one-hot grant, its binary index and an any-request flag.
module cpu6_rr_pick #(
  parameter int NUM  = 5,
  parameter int SRCW = 3
) (
  input  logic [NUM-1:0]  i_req,
  input  logic [SRCW-1:0] i_ptr,
  output logic [NUM-1:0]  o_grant,
  output logic [SRCW-1:0] o_gidx,
  output logic            o_any
);

  // Rotating priority search starting at the pointer; first hit wins.
  always_comb begin
    logic            w_found;
    logic [SRCW-1:0] w_idx;
    int              j;
    o_grant = '0;
    o_gidx  = '0;
    o_any   = |i_req;
    w_found = 1'b0;
    w_idx   = '0;
    j       = 0;
    for (int k = 0; k < NUM; k++) begin
      j = int'(i_ptr) + k;
      if (j >= NUM) j = j - NUM;
      w_idx = SRCW'(j);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_gidx         = w_idx;
      end
    end
  end

endmodule

// File: rtl/cpu6_arb_muxnds.sv
// cpu6_arb_muxnds: parametrised N:1 datapath mux with active-low channel masks,
// round-robin arbitration, a registered valid/ready output stage and an optional
// packet lock enabled by defining CPU6_ARB_LOCK_EN.
//
// Handshake: a beat moves from channel i when in_valid[i] & in_ready[i] at posedge;
// the held beat moves to the consumer when out_valid & out_ready at posedge.
// in_ready never depends on out_valid falling first: a drain and a load share a cycle.
module cpu6_arb_muxnds
  import cpu6_arb_muxnds_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NUM   = 5,
  parameter int SRCW  = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM-1:0]       sel_l,
  input  logic [NUM-1:0]       in_valid,
  input  logic [NUM*WIDTH-1:0] in_data,
  input  logic [NUM-1:0]       in_lock,
  output logic [NUM-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SRCW-1:0]      out_src,
  input  logic                 out_ready,
  output logic                 o_dbg_state
);

  logic [SRCW-1:0]  r_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SRCW-1:0]  r_out_src;

  logic [NUM-1:0]   w_req;
  logic [NUM-1:0]   w_grant;
  logic [SRCW-1:0]  w_gidx;
  logic             w_any;
  logic             w_load;
  logic [WIDTH-1:0] w_mux_data;

`ifdef CPU6_ARB_LOCK_EN
  arb_state_e       r_state;
  logic [SRCW-1:0]  r_lock_idx;
  logic [NUM-1:0]   w_lock_mask;

  // While locked only the owning channel may request, regardless of its mask.
  always_comb begin
    w_lock_mask             = '0;
    w_lock_mask[r_lock_idx] = 1'b1;
    if (r_state == ST_LOCK) w_req = in_valid & w_lock_mask;
    else                    w_req = in_valid & ~sel_l;
  end

  assign o_dbg_state = r_state;
`else
  // Without the lock feature every beat re-arbitrates among unmasked channels.
  always_comb begin
    w_req = in_valid & ~sel_l;
  end

  logic w_unused_lock;
  assign w_unused_lock = ^in_lock;
  assign o_dbg_state   = ST_IDLE;
`endif

  cpu6_rr_pick #(
    .NUM  (NUM),
    .SRCW (SRCW)
  ) u_pick (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_gidx  (w_gidx),
    .o_any   (w_any)
  );

  // Load when something is requested and the output register is free or draining now.
  assign w_load   = w_any & (~r_out_valid | out_ready) & resetn;
  assign in_ready = w_grant & {NUM{w_load}};

  // AND-OR data mux on the one-hot grant.
  always_comb begin
    w_mux_data = '0;
    for (int i = 0; i < NUM; i++) begin
      w_mux_data = w_mux_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
    end
  end

  // Output register, round-robin pointer and lock FSM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_ptr       <= '0;
`ifdef CPU6_ARB_LOCK_EN
      r_state     <= ST_IDLE;
      r_lock_idx  <= '0;
`endif
    end else begin
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mux_data;
        r_out_src   <= w_gidx;
`ifdef CPU6_ARB_LOCK_EN
        if (in_lock[w_gidx]) begin
          // Mid-packet beat: hold the pointer so the packet owner keeps priority.
          r_state    <= ST_LOCK;
          r_lock_idx <= w_gidx;
        end else begin
          r_state    <= ST_IDLE;
          r_ptr      <= SRCW'(rr_next(int'(w_gidx), NUM));
        end
`else
        r_ptr       <= SRCW'(rr_next(int'(w_gidx), NUM));
`endif
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_cpu6_arb_muxnds.sv
// Directed bench for cpu6_arb_muxnds with NUM=5, WIDTH=32.
// Lock expectations follow CPU6_ARB_LOCK_EN as seen by this compilation.
module tb_cpu6_arb_muxnds;

  localparam int WIDTH = 32;
  localparam int NUM   = 5;
  localparam int SRCW  = 3;

  logic                 clk;
  logic                 resetn;
  logic [NUM-1:0]       sel_l;
  logic [NUM-1:0]       in_valid;
  logic [NUM*WIDTH-1:0] in_data;
  logic [NUM-1:0]       in_lock;
  logic [NUM-1:0]       in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SRCW-1:0]      out_src;
  logic                 out_ready;
  logic                 dbg_state;

  logic [WIDTH-1:0]     ch_data [NUM];

  int n_checks;
  int n_errors;

  assign in_data = {ch_data[4], ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

  cpu6_arb_muxnds #(
    .WIDTH (WIDTH),
    .NUM   (NUM),
    .SRCW  (SRCW)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .sel_l       (sel_l),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_lock     (in_lock),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_src     (out_src),
    .out_ready   (out_ready),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle past it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_default_data();
    ch_data[0] = 32'h1000_0000;
    ch_data[1] = 32'h2111_1111;
    ch_data[2] = 32'h3222_2222;
    ch_data[3] = 32'h4333_3333;
    ch_data[4] = 32'h5444_4444;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    sel_l     = '0;
    in_valid  = '0;
    in_lock   = '0;
    out_ready = 1'b1;
    set_default_data();
    cycle();
    cycle();
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    sel_l     = '0;
    in_valid  = 5'h1F;
    in_lock   = '0;
    out_ready = 1'b1;
    set_default_data();
    cycle();
    cycle();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid);
    end
    n_checks++;
    if (in_ready !== 5'b00000) begin
      n_errors++; $display("FAIL reset_in_ready got %b want 00000", in_ready);
    end
    n_checks++;
    if (out_src !== 3'd0 || out_data !== 32'h0) begin
      n_errors++; $display("FAIL reset_out_regs got src=%0d data=%h want 0/0", out_src, out_data);
    end
    n_checks++;
    if (dbg_state !== 1'b0) begin
      n_errors++; $display("FAIL reset_state got %0b want 0", dbg_state);
    end
    resetn = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 5'b00001) begin
      n_errors++; $display("FAIL reset_first_grant got %b want 00001", in_ready);
    end
    cycle();
    n_checks++;
    if (out_valid !== 1'b1 || out_src !== 3'd0 || out_data !== 32'h1000_0000) begin
      n_errors++;
      $display("FAIL reset_first_beat got v=%0b src=%0d data=%h want 1/0/10000000",
               out_valid, out_src, out_data);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_src [6];
    logic [4:0] exp_rdy [6];
    exp_src = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    exp_rdy = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    do_reset();
    in_valid = 5'h1F;
    #1;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (in_ready !== exp_rdy[k]) begin
        n_errors++; $display("FAIL rr_in_ready[%0d] got %b want %b", k, in_ready, exp_rdy[k]);
      end
      cycle();
      n_checks++;
      if (out_valid !== 1'b1 || out_src !== exp_src[k] || out_data !== ch_data[exp_src[k]]) begin
        n_errors++;
        $display("FAIL rr_beat[%0d] got v=%0b src=%0d data=%h want 1/%0d/%h",
                 k, out_valid, out_src, out_data, exp_src[k], ch_data[exp_src[k]]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ch_data[0] = 32'hDEAD_BEEF;
    in_valid   = 5'b00001;
    cycle();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF || out_src !== 3'd0) begin
      n_errors++; $display("FAIL bp_load got v=%0b src=%0d data=%h want 1/0/deadbeef",
                           out_valid, out_src, out_data);
    end
    out_ready  = 1'b0;
    in_valid   = 5'h1F;
    ch_data[0] = 32'h0BAD_0BAD;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (in_ready !== 5'b00000) begin
        n_errors++; $display("FAIL bp_stall_ready[%0d] got %b want 00000", k, in_ready);
      end
      cycle();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF || out_src !== 3'd0) begin
        n_errors++; $display("FAIL bp_hold[%0d] got v=%0b src=%0d data=%h want 1/0/deadbeef",
                             k, out_valid, out_src, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 5'b00010) begin
      n_errors++; $display("FAIL bp_release_ready got %b want 00010", in_ready);
    end
    cycle();
    n_checks++;
    if (out_valid !== 1'b1 || out_src !== 3'd1 || out_data !== 32'h2111_1111) begin
      n_errors++; $display("FAIL bp_release_beat got v=%0b src=%0d data=%h want 1/1/21111111",
                           out_valid, out_src, out_data);
    end
  endtask

  task automatic test_mask();
    logic [2:0] exp_src [4];
    logic [4:0] exp_rdy [4];
    exp_src = '{3'd1, 3'd3, 3'd4, 3'd1};
    exp_rdy = '{5'b00010, 5'b01000, 5'b10000, 5'b00010};
    do_reset();
    sel_l    = 5'b00101;
    in_valid = 5'h1F;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (in_ready !== exp_rdy[k]) begin
        n_errors++; $display("FAIL mask_in_ready[%0d] got %b want %b", k, in_ready, exp_rdy[k]);
      end
      cycle();
      n_checks++;
      if (out_src !== exp_src[k] || out_data !== ch_data[exp_src[k]]) begin
        n_errors++; $display("FAIL mask_beat[%0d] got src=%0d want %0d", k, out_src, exp_src[k]);
      end
    end
  endtask

  task automatic test_wrap_sparse();
    do_reset();
    in_valid = 5'h1F;
    for (int k = 0; k < 4; k++) cycle();
    in_valid = 5'b00100;
    #1;
    n_checks++;
    if (in_ready !== 5'b00100) begin
      n_errors++; $display("FAIL wrap_sparse_ready got %b want 00100", in_ready);
    end
    cycle();
    n_checks++;
    if (out_src !== 3'd2 || out_data !== 32'h3222_2222) begin
      n_errors++; $display("FAIL wrap_sparse_beat got src=%0d want 2", out_src);
    end
    in_valid = 5'b10001;
    #1;
    n_checks++;
    if (in_ready !== 5'b10000) begin
      n_errors++; $display("FAIL wrap_ch4_first_ready got %b want 10000", in_ready);
    end
    cycle();
    n_checks++;
    if (out_src !== 3'd4) begin
      n_errors++; $display("FAIL wrap_ch4_first_beat got src=%0d want 4", out_src);
    end
    #1;
    n_checks++;
    if (in_ready !== 5'b00001) begin
      n_errors++; $display("FAIL wrap_to_ch0_ready got %b want 00001", in_ready);
    end
    cycle();
    n_checks++;
    if (out_src !== 3'd0 || out_data !== 32'h1000_0000) begin
      n_errors++; $display("FAIL wrap_to_ch0_beat got src=%0d want 0", out_src);
    end
  endtask

  task automatic test_drain_idle();
    // All channels masked while valid: nothing loads, held beat drains.
    sel_l    = 5'h1F;
    in_valid = 5'h1F;
    #1;
    n_checks++;
    if (in_ready !== 5'b00000) begin
      n_errors++; $display("FAIL idle_in_ready got %b want 00000", in_ready);
    end
    cycle();
    n_checks++;
    if (out_valid !== 1'b0 || out_src !== 3'd0 || out_data !== 32'h1000_0000) begin
      n_errors++; $display("FAIL idle_drain got v=%0b src=%0d data=%h want 0/0/10000000",
                           out_valid, out_src, out_data);
    end
    sel_l = '0;
  endtask

  task automatic test_lock();
    logic [2:0] exp_src [4];
    logic [4:0] lock_vec [4];
    logic       exp_st [4];
`ifdef CPU6_ARB_LOCK_EN
    exp_src = '{3'd2, 3'd2, 3'd2, 3'd3};
    exp_st  = '{1'b1, 1'b1, 1'b0, 1'b0};
`else
    exp_src = '{3'd2, 3'd3, 3'd4, 3'd0};
    exp_st  = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    lock_vec = '{5'b00100, 5'b00100, 5'b00000, 5'b00000};
    do_reset();
    in_valid = 5'h1F;
    cycle();
    cycle();
    for (int k = 0; k < 4; k++) begin
      in_lock = lock_vec[k];
      cycle();
      n_checks++;
      if (out_src !== exp_src[k] || dbg_state !== exp_st[k]) begin
        n_errors++; $display("FAIL lock_beat[%0d] got src=%0d st=%0b want %0d/%0b",
                             k, out_src, dbg_state, exp_src[k], exp_st[k]);
      end
    end
    in_lock = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_mask();
    test_wrap_sparse();
    test_drain_idle();
    test_lock();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
